// File: rtl/ksa_pkg.sv
// Shared types and constants for the RC4 key-scheduling stage (ksa).
package ksa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RDI,
        LDI,
        RDJ,
        LDJ,
        WRI,
        WRJ
    } state_e;

    localparam int DEFAULT_KEY_BYTES = 3;
    localparam int DEFAULT_MEM_DEPTH = 256;

    // Cycles from presenting addr (wren=0) to rddata being valid.
    localparam int RD_LATENCY = 1;

endpackage

// File: rtl/ksa_keysel.sv
// Key-byte selector for ksa: latches the key and walks its bytes
// MSB-first with a mod-KEY_BYTES counter that advances once per iteration.
module ksa_keysel
    import ksa_pkg::*;
#(
    parameter int KEY_BYTES = DEFAULT_KEY_BYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   adv,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             keybyte
);

    localparam int IDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_BYTES - 1);

    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;

    always_comb begin
        idx_d = idx_q;
        key_d = key_q;
        if (clr) begin
            idx_d = '0;
            key_d = key;
        end else if (adv) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            key_q <= '0;
        end else begin
            idx_q <= idx_d;
            key_q <= key_d;
        end
    end

    // Byte 0 sits in the most significant position of the key.
    always_comb begin
        keybyte = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (idx_q == IDX_W'(b)) begin
                keybyte = key_q[8*(KEY_BYTES-1-b) +: 8];
            end
        end
    end

endmodule

// File: rtl/ksa.sv
// RC4 key-scheduling stage: permutes the shared 256x8 S RAM in place.
// Optional build macro KSA_SKIP_SELF_SWAP_EN skips both writes when j==i.
module ksa
    import ksa_pkg::*;
#(
    parameter int KEY_BYTES = DEFAULT_KEY_BYTES,
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             addr,
    input  logic [7:0]             rddata,
    output logic [7:0]             wrdata,
    output logic                   wren
);

    if (MEM_DEPTH != 256 || RD_LATENCY != 1) begin : gBadConfig
        $error("ksa: MEM_DEPTH must be 256 and RAM read latency must be 1");
    end

    localparam logic [7:0] LAST_I = 8'(MEM_DEPTH - 1);

    state_e     state_q, state_d;
    logic [7:0] i_q, i_d;
    logic [7:0] j_q, j_d;
    logic [7:0] si_q, si_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wrdata_q, wrdata_d;
    logic       wren_q, wren_d;

    logic       keyClr;
    logic       keyAdv;
    logic [7:0] keybyte;
    logic [7:0] jNext;
    logic       endIter;

    ksa_keysel #(
        .KEY_BYTES(KEY_BYTES)
    ) u_keysel (
        .clk    (clk),
        .rst    (rst),
        .clr    (keyClr),
        .adv    (keyAdv),
        .key    (key),
        .keybyte(keybyte)
    );

    assign jNext = j_q + rddata + keybyte;

    // Outputs are registered: each state's addr/wrdata/wren are set up on
    // the edge that enters it, so the RAM sees them for that whole cycle.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        si_d     = si_q;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        wren_d   = 1'b0;
        keyClr   = 1'b0;
        keyAdv   = 1'b0;
        endIter  = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    keyClr  = 1'b1;
                    i_d     = '0;
                    j_d     = '0;
                    addr_d  = '0;
                    state_d = RDI;
                end
            end
            RDI: state_d = LDI;
            LDI: begin
                si_d    = rddata;
                j_d     = jNext;
                addr_d  = jNext;
                state_d = RDJ;
            end
            RDJ: state_d = LDJ;
            LDJ: begin
`ifdef KSA_SKIP_SELF_SWAP_EN
                if (j_q == i_q) begin
                    endIter = 1'b1;
                end else begin
                    wrdata_d = rddata;
                    addr_d   = i_q;
                    wren_d   = 1'b1;
                    state_d  = WRI;
                end
`else
                wrdata_d = rddata;
                addr_d   = i_q;
                wren_d   = 1'b1;
                state_d  = WRI;
`endif
            end
            WRI: begin
                wrdata_d = si_q;
                addr_d   = j_q;
                wren_d   = 1'b1;
                state_d  = WRJ;
            end
            WRJ: endIter = 1'b1;
            default: state_d = IDLE;
        endcase

        if (endIter) begin
            keyAdv = 1'b1;
            if (i_q == LAST_I) begin
                state_d = IDLE;
            end else begin
                i_d     = i_q + 8'd1;
                addr_d  = i_q + 8'd1;
                state_d = RDI;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            si_q     <= '0;
            addr_q   <= '0;
            wrdata_q <= '0;
            wren_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            si_q     <= si_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            wren_q   <= wren_d;
        end
    end

    assign rdy    = (state_q == IDLE);
    assign addr   = addr_q;
    assign wrdata = wrdata_q;
    assign wren   = wren_q;

endmodule

// File: tb/tb_ksa.sv
// Self-checking bench for ksa: behavioural S RAM plus a plain RC4 KSA model.
// Build with KSA_SKIP_SELF_SWAP_EN defined to check the self-swap skip variant.
module tb_ksa;

`ifdef KSA_SKIP_SELF_SWAP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  addr;
    logic [7:0]  rddata;
    logic [7:0]  wrdata;
    logic        wren;

    int vectors;
    int miscompares;

    logic [7:0] mem[256];
    logic [7:0] initS[256];
    logic       loadS;

    logic [7:0] modelS[256];
    int         modelSelf;
    logic [7:0] modelWrA[$];
    logic [7:0] modelWrD[$];
    logic [7:0] dutWrA[$];
    logic [7:0] dutWrD[$];

    ksa dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .rdy   (rdy),
        .key   (key),
        .addr  (addr),
        .rddata(rddata),
        .wrdata(wrdata),
        .wren  (wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port S RAM with one cycle of read latency and a bulk preload.
    always @(posedge clk) begin
        if (loadS) begin
            for (int k = 0; k < 256; k++) mem[k] <= initS[k];
        end else if (wren) begin
            mem[addr] <= wrdata;
        end
        rddata <= mem[addr];
    end

    // Reference RC4 key schedule over modelS, also listing the RAM writes.
    task automatic modelKsa(input logic [23:0] k);
        logic [7:0] kb[3];
        logic [7:0] jj;
        logic [7:0] t;
        kb[0] = k[23:16];
        kb[1] = k[15:8];
        kb[2] = k[7:0];
        jj = 8'd0;
        modelSelf = 0;
        modelWrA.delete();
        modelWrD.delete();
        for (int ii = 0; ii < 256; ii++) begin
            jj = jj + modelS[ii] + kb[ii % 3];
            if (ii == int'(jj)) modelSelf++;
            if (!(SKIP && ii == int'(jj))) begin
                modelWrA.push_back(8'(ii));
                modelWrD.push_back(modelS[jj]);
                modelWrA.push_back(jj);
                modelWrD.push_back(modelS[ii]);
            end
            t = modelS[ii];
            modelS[ii] = modelS[jj];
            modelS[jj] = t;
        end
    endtask

    task automatic preload(input bit identity);
        for (int k = 0; k < 256; k++) initS[k] = identity ? 8'(k) : mem[k];
        @(negedge clk);
        loadS = 1'b1;
        @(negedge clk);
        loadS = 1'b0;
        for (int k = 0; k < 256; k++) modelS[k] = initS[k];
    endtask

    task automatic applyStimulus(input logic [23:0] k, input int disturbAt,
                                 output int busy, output int nWrites, output bit timedOut);
        dutWrA.delete();
        dutWrD.delete();
        busy = 0;
        nWrites = 0;
        timedOut = 1'b1;
        @(negedge clk);
        key = k;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (rdy) begin
                timedOut = 1'b0;
                break;
            end
            busy++;
            if (wren) begin
                nWrites++;
                dutWrA.push_back(addr);
                dutWrD.push_back(wrdata);
            end
            if (busy == disturbAt) begin
                en = 1'b1;
                key = 24'hFFFFFF;
            end else begin
                en = 1'b0;
            end
            @(negedge clk);
        end
        en = 1'b0;
    endtask

    task automatic checkRun(input string tag, input int busy, input int nWrites, input bit timedOut);
        int expBusy;
        int expWrites;
        int diffs;
        int firstDiff;
        expBusy   = SKIP ? 1536 - 2 * modelSelf : 1536;
        expWrites = SKIP ? 2 * (256 - modelSelf) : 512;

        vectors++;
        if (timedOut) begin
            miscompares++;
            $display("[TB] FAIL %s_timeout: rdy did not return within 3000 cycles", tag);
        end
        vectors++;
        if (busy !== expBusy) begin
            miscompares++;
            $display("[TB] FAIL %s_busy: got %0d busy cycles, expected %0d", tag, busy, expBusy);
        end
        vectors++;
        if (busy + 1 !== expBusy + 1) begin
            miscompares++;
            $display("[TB] FAIL %s_rdy_rise: rdy rose %0d cycles after en, expected %0d", tag, busy + 1, expBusy + 1);
        end
        vectors++;
        if (nWrites !== expWrites) begin
            miscompares++;
            $display("[TB] FAIL %s_writes: got %0d wren cycles, expected %0d", tag, nWrites, expWrites);
        end

        diffs = 0;
        firstDiff = -1;
        if (dutWrA.size() != modelWrA.size()) begin
            diffs = 1;
        end else begin
            for (int w = 0; w < dutWrA.size(); w++) begin
                if (dutWrA[w] !== modelWrA[w] || dutWrD[w] !== modelWrD[w]) begin
                    diffs++;
                    if (firstDiff < 0) firstDiff = w;
                end
            end
        end
        vectors++;
        if (diffs != 0) begin
            miscompares++;
            $display("[TB] FAIL %s_write_log: %0d entries (expected %0d), %0d differ, first at %0d",
                     tag, dutWrA.size(), modelWrA.size(), diffs, firstDiff);
        end

        diffs = 0;
        firstDiff = -1;
        for (int k = 0; k < 256; k++) begin
            if (mem[k] !== modelS[k]) begin
                diffs++;
                if (firstDiff < 0) firstDiff = k;
            end
        end
        vectors++;
        if (diffs != 0) begin
            miscompares++;
            $display("[TB] FAIL %s_final_S: %0d bytes differ, first S[%0d]=%h expected %h",
                     tag, diffs, firstDiff, mem[firstDiff], modelS[firstDiff]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b0;
        key = 24'h0;
        loadS = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            vectors++;
            if (rdy !== 1'b1 || wren !== 1'b0 || addr !== 8'h00) begin
                miscompares++;
                $display("[TB] FAIL reset_idle: cycle %0d rdy=%b wren=%b addr=%h, expected rdy=1 wren=0 addr=00",
                         c, rdy, wren, addr);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_identity_key0();
        int busy, nWrites, off;
        bit to;
        preload(1'b1);
        modelKsa(24'h000000);
        applyStimulus(24'h000000, -1, busy, nWrites, to);
        checkRun("key0", busy, nWrites, to);
        off = SKIP ? 0 : 4;
        vectors++;
        if (dutWrA.size() < off + 2) begin
            miscompares++;
            $display("[TB] FAIL key0_iter2: only %0d writes logged", dutWrA.size());
        end else if (dutWrA[off] !== 8'h02 || dutWrD[off] !== 8'h03 ||
                     dutWrA[off+1] !== 8'h03 || dutWrD[off+1] !== 8'h02) begin
            miscompares++;
            $display("[TB] FAIL key0_iter2: got (%h,%h),(%h,%h), expected (02,03),(03,02)",
                     dutWrA[off], dutWrD[off], dutWrA[off+1], dutWrD[off+1]);
        end
    endtask

    task automatic test_golden_key();
        int busy, nWrites;
        bit to;
        preload(1'b1);
        modelKsa(24'h00033C);
        applyStimulus(24'h00033C, -1, busy, nWrites, to);
        checkRun("key33c", busy, nWrites, to);
    endtask

    task automatic test_random_keys();
        int busy, nWrites;
        bit to;
        logic [23:0] k;
        for (int r = 0; r < 3; r++) begin
            k = 24'($urandom);
            // Start from whatever S holds (a previous permutation) to vary the data.
            preload(r == 0);
            modelKsa(k);
            applyStimulus(k, -1, busy, nWrites, to);
            checkRun($sformatf("rand%0d", r), busy, nWrites, to);
        end
    endtask

    task automatic test_en_ignored();
        int busy, nWrites;
        bit to;
        preload(1'b1);
        modelKsa(24'h00033C);
        applyStimulus(24'h00033C, 100, busy, nWrites, to);
        checkRun("en_busy", busy, nWrites, to);
    endtask

    task automatic test_reset_midrun();
        int busy, nWrites;
        bit to;
        preload(1'b1);
        @(negedge clk);
        key = 24'h00033C;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (699) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (rdy !== 1'b1 || wren !== 1'b0 || addr !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL midrun_reset: rdy=%b wren=%b addr=%h, expected rdy=1 wren=0 addr=00",
                     rdy, wren, addr);
        end
        rst = 1'b0;
        for (int k = 0; k < 256; k++) modelS[k] = mem[k];
        modelKsa(24'h000000);
        applyStimulus(24'h000000, -1, busy, nWrites, to);
        checkRun("after_reset", busy, nWrites, to);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_identity_key0();
        test_golden_key();
        test_en_ignored();
        test_reset_midrun();
        test_random_keys();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
